face_box_tracker: RTL and testbench
===================================

Name: face_box_tracker

Overview:
- Sits directly downstream of the binarised-face stage.
- Consumes its pixel pack, in which a face pixel is white and a background pixel is black.
- Accumulates the bounding box and pixel count of face pixels over each frame, latches the result at the next frame start, and exports box corners and centre for the aim logic.
- Outputs the same pixel stream one cycle later, with the last valid box drawn over it as a 1-pixel rectangle outline.

Parameters:
- H_ACT, 1276: active width of the incoming stream (post 3x3 matrix crop).
- V_ACT, 716: active height of the incoming stream.
- MIN_PIXELS, 64: minimum face-pixel count per frame for the box to be valid.
- BOX_COLOR, 24'hFF0000: RGB written on box outline pixels.
- Derived localparams:
  - XW = $clog2(H_ACT)
  - YW = $clog2(V_ACT)
  - CW = $clog2(H_ACT*V_ACT+1)
  - PACK_SIZE = 3*8+4+XW+YW

Ports:
- clk  input  1  pixel clock.
- rstn  input  1  asynchronous active-low reset.
- en  input  1  overlay enable. Tracking runs regardless of en.
- i_pack  input  PACK_SIZE  pixel pack, MSB first: {pclk, hsync, vsync, de, r[7:0], g[7:0], b[7:0], x[XW-1:0], y[YW-1:0]}.
- o_pack  output  PACK_SIZE  same layout as i_pack, 1-cycle latency, rgb possibly overlaid.
- box_valid  output  1  latched box is valid for the current frame.
- box_x0  output  XW  left edge (minimum x).
- box_x1  output  XW  right edge (maximum x).
- box_y0  output  YW  top edge (minimum y).
- box_y1  output  YW  bottom edge (maximum y).
- box_cx  output  XW  (box_x0+box_x1)>>1.
- box_cy  output  YW  (box_y0+box_y1)>>1.
- frame_done  output  1  one-cycle pulse when a frame result is latched.

Behaviour:
- Reset (rstn=0, asynchronous), all of the following until released:
  - o_pack = 0, box_valid = 0, all box_* outputs = 0, frame_done = 0.
  - Accumulators at initial values: min_x = H_ACT-1, max_x = 0, min_y = V_ACT-1, max_y = 0, cnt = 0.
  - vs_d = 0.
- Face pixel definition: de=1 and r[7]=1. Only the r channel MSB is tested.
- Frame start:
  - vs_d registers the vsync bit every cycle.
  - Frame start (fs) = vsync & ~vs_d, i.e. vsync is active-high.
- Accumulation on each face pixel, when not fs:
  - min_x = min(min_x, x); max_x = max(max_x, x); min_y = min(min_y, y); max_y = max(max_y, y).
  - cnt increments and saturates at 2^CW-1.
- On the fs cycle:
  - If cnt >= MIN_PIXELS (saturated cnt counts as valid): box_x0/x1/y0/y1 are loaded from the accumulators, box_cx/box_cy from the registered sums shifted right by 1 (sum computed at XW+1 / YW+1 bits), and box_valid = 1.
  - Otherwise box_valid = 0 and box_* hold their previous values.
  - frame_done = 1 for exactly this cycle.
  - Accumulators reload their initial values.
  - If de=1 and the pixel is a face pixel on this same cycle, that pixel seeds the new frame: min = max = its x/y, cnt = 1.
- The accumulators form a 2-phase FSM:
  - IDLE: after reset, before the first fs. Face pixels are ignored; box_valid stays 0.
  - ACCUM: entered on the first fs.
  - Every later fs latches the result and stays in ACCUM.
  - A partial first frame after reset is therefore never reported.
- Overlay:
  - The pixel is on the outline when en=1, box_valid=1, de=1, and either:
    - (x==box_x0 or x==box_x1) and box_y0<=y<=box_y1, or
    - (y==box_y0 or y==box_y1) and box_x0<=x<=box_x1.
  - On the outline, o_pack rgb = BOX_COLOR; otherwise rgb passes unchanged.
  - All non-rgb fields always pass unchanged.
  - The comparison uses box_* values as they stand in the cycle i_pack is sampled. A box updated at fs therefore applies from the next pixel onward.
- Degenerate box: a single face pixel repeated (box_x0==box_x1, box_y0==box_y1) draws exactly that one pixel.
- Coordinates are trusted. x >= H_ACT or y >= V_ACT is not checked.
- Reset mid-frame discards the accumulators and returns the FSM to IDLE.

Test Plan:
- Reset release, then 3 frames of 8x8 stream (H_ACT=8, V_ACT=8, MIN_PIXELS=4), all black -> frame_done pulses at fs 2 and 3, box_valid stays 0, o_pack = i_pack delayed 1 cycle.
- Frame with face pixels at (2,3), (5,3), (4,6) and one extra at (3,4) -> at next fs box = x0 2, x1 5, y0 3, y1 6, cx 3, cy 4, box_valid = 1.
- Following frame, en=1, all black input -> outline pixels, e.g. (2,3), (5,6), (2,5), (4,3), output rgb FF0000; (3,4) unchanged. At the end of this frame box_valid drops to 0 and box_* hold.
- Same box, en=0 -> no overlay, box_* still update.
- Only 3 face pixels in a frame -> box_valid = 0 after fs. Face pixel driven with de=1 on the fs cycle -> counted in the new frame (cnt=1 seed).
- Assert rstn low mid-frame with face pixels present -> outputs 0 immediately. The next fs does not set box_valid; the following fs reports correctly.

Source files
------------

// File: rtl/face_box_tracker.sv
// face_box_tracker: per-frame bounding box of face pixels (de & r[7]), latched at frame start,
// exported as corners/centre and drawn as a 1-pixel outline on the 1-cycle-delayed stream.
module face_box_tracker #(
  parameter int          H_ACT      = 1276,
  parameter int          V_ACT      = 716,
  parameter int          MIN_PIXELS = 64,
  parameter logic [23:0] BOX_COLOR  = 24'hFF0000,
  localparam int XW        = $clog2(H_ACT),
  localparam int YW        = $clog2(V_ACT),
  localparam int CW        = $clog2(H_ACT*V_ACT+1),
  localparam int PACK_SIZE = 3*8+4+XW+YW
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic [PACK_SIZE-1:0] i_pack,
  output logic [PACK_SIZE-1:0] o_pack,
  output logic                 box_valid,
  output logic [XW-1:0]        box_x0,
  output logic [XW-1:0]        box_x1,
  output logic [YW-1:0]        box_y0,
  output logic [YW-1:0]        box_y1,
  output logic [XW-1:0]        box_cx,
  output logic [YW-1:0]        box_cy,
  output logic                 frame_done
);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state_q, state_d;
  logic vsync, de, face, fs, acc_en, latch, seed, valid_now, load, on_box;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic vs_q;
  logic [XW-1:0] min_x_q, min_x_d, max_x_q, max_x_d;
  logic [YW-1:0] min_y_q, min_y_d, max_y_q, max_y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic bv_q, bv_d, fd_q;
  logic [XW-1:0] bx0_q, bx0_d, bx1_q, bx1_d, bcx_q, bcx_d;
  logic [YW-1:0] by0_q, by0_d, by1_q, by1_d, bcy_q, bcy_d;
  logic [PACK_SIZE-1:0] o_pack_q, o_pack_d;

  assign vsync = i_pack[PACK_SIZE-3];
  assign de    = i_pack[PACK_SIZE-4];
  assign face  = de & i_pack[PACK_SIZE-5];
  assign px    = i_pack[YW +: XW];
  assign py    = i_pack[YW-1:0];
  assign fs    = vsync & ~vs_q;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state_q <= IDLE;
    else state_q <= state_d;

  always_comb state_d = fs ? ACCUM : state_q;

  // The new frame's first pixel may coincide with fs; it seeds the accumulators rather than being lost.
  always_comb begin
    acc_en = (state_q == ACCUM) & face & ~fs;
    latch  = (state_q == ACCUM) & fs;
    seed   = fs & face;
  end

  always_comb begin
    min_x_d   = seed ? px : fs ? XW'(H_ACT-1) : (acc_en && px < min_x_q) ? px : min_x_q;
    max_x_d   = seed ? px : fs ? '0 : (acc_en && px > max_x_q) ? px : max_x_q;
    min_y_d   = seed ? py : fs ? YW'(V_ACT-1) : (acc_en && py < min_y_q) ? py : min_y_q;
    max_y_d   = seed ? py : fs ? '0 : (acc_en && py > max_y_q) ? py : max_y_q;
    cnt_d     = seed ? CW'(1) : fs ? '0 : (acc_en && cnt_q != '1) ? cnt_q + CW'(1) : cnt_q;
    valid_now = cnt_q >= CW'(MIN_PIXELS);
    load      = latch & valid_now;
    bv_d      = latch ? valid_now : bv_q;
    bx0_d     = load ? min_x_q : bx0_q;
    bx1_d     = load ? max_x_q : bx1_q;
    by0_d     = load ? min_y_q : by0_q;
    by1_d     = load ? max_y_q : by1_q;
    bcx_d     = load ? XW'(((XW+1)'(min_x_q) + (XW+1)'(max_x_q)) >> 1) : bcx_q;
    bcy_d     = load ? YW'(((YW+1)'(min_y_q) + (YW+1)'(max_y_q)) >> 1) : bcy_q;
  end

  // Outline test uses the box as currently registered, so a fresh box applies from the next pixel.
  always_comb begin
    on_box   = en & bv_q & de &
               (((px == bx0_q || px == bx1_q) && py >= by0_q && py <= by1_q) ||
                ((py == by0_q || py == by1_q) && px >= bx0_q && px <= bx1_q));
    o_pack_d = on_box ? {i_pack[PACK_SIZE-1 -: 4], BOX_COLOR, i_pack[XW+YW-1:0]} : i_pack;
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      vs_q     <= 1'b0;
      min_x_q  <= XW'(H_ACT-1);
      max_x_q  <= '0;
      min_y_q  <= YW'(V_ACT-1);
      max_y_q  <= '0;
      cnt_q    <= '0;
      bv_q     <= 1'b0;
      bx0_q    <= '0;
      bx1_q    <= '0;
      by0_q    <= '0;
      by1_q    <= '0;
      bcx_q    <= '0;
      bcy_q    <= '0;
      fd_q     <= 1'b0;
      o_pack_q <= '0;
    end else begin
      vs_q     <= vsync;
      min_x_q  <= min_x_d;
      max_x_q  <= max_x_d;
      min_y_q  <= min_y_d;
      max_y_q  <= max_y_d;
      cnt_q    <= cnt_d;
      bv_q     <= bv_d;
      bx0_q    <= bx0_d;
      bx1_q    <= bx1_d;
      by0_q    <= by0_d;
      by1_q    <= by1_d;
      bcx_q    <= bcx_d;
      bcy_q    <= bcy_d;
      fd_q     <= latch;
      o_pack_q <= o_pack_d;
    end

  assign o_pack     = o_pack_q;
  assign box_valid  = bv_q;
  assign box_x0     = bx0_q;
  assign box_x1     = bx1_q;
  assign box_y0     = by0_q;
  assign box_y1     = by1_q;
  assign box_cx     = bcx_q;
  assign box_cy     = bcy_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_face_box_tracker.sv
// tb_face_box_tracker: directed 8x8 frames exercising box latch, validity threshold, fs seeding,
// overlay on/off and mid-frame reset, with hand-computed boxes.
module tb_face_box_tracker;
  localparam int PS = 34;
  logic clk = 1'b0, rstn = 1'b1, en = 1'b0;
  logic [PS-1:0] i_pack = '0, o_pack;
  logic box_valid, frame_done;
  logic [2:0] box_x0, box_x1, box_y0, box_y1, box_cx, box_cy;
  int n_chk = 0, n_fail = 0;
  logic m_v = 1'b0;
  logic [2:0] m_x0 = 0, m_x1 = 0, m_y0 = 0, m_y1 = 0;

  face_box_tracker #(.H_ACT(8), .V_ACT(8), .MIN_PIXELS(4), .BOX_COLOR(24'hFF0000)) dut (
    .clk(clk), .rstn(rstn), .en(en), .i_pack(i_pack), .o_pack(o_pack),
    .box_valid(box_valid), .box_x0(box_x0), .box_x1(box_x1), .box_y0(box_y0), .box_y1(box_y1),
    .box_cx(box_cx), .box_cy(box_cy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pt(input int x, input int y);
    return 64'd1 << (y*8 + x);
  endfunction

  function automatic logic on_box(input logic [2:0] x, input logic [2:0] y);
    return ((x == m_x0 || x == m_x1) && y >= m_y0 && y <= m_y1) ||
           ((y == m_y0 || y == m_y1) && x >= m_x0 && x <= m_x1);
  endfunction

  task automatic drive(input logic vs, input logic d, input logic [7:0] r, input logic [2:0] x, input logic [2:0] y);
    logic [PS-1:0] exp;
    i_pack = {1'b0, x == 3'd0, vs, d, r, {x, y, 2'b01}, {y, x, 2'b10}, x, y};
    exp = i_pack;
    if (en && m_v && d && on_box(x, y)) exp[29:6] = 24'hFF0000;
    @(posedge clk); #1;
    check("o_pack", o_pack, exp);
  endtask

  task automatic frame(input logic [63:0] map, input int rows, input logic fd, input logic [2:0] fx,
                       input logic [2:0] fy, input logic ed, input logic ev, input logic [2:0] x0,
                       input logic [2:0] x1, input logic [2:0] y0, input logic [2:0] y1,
                       input logic [2:0] cx, input logic [2:0] cy);
    drive(1'b1, fd, fd ? 8'hFF : 8'h7F, fx, fy);
    check("frame_done", frame_done, ed);
    check("box_valid", box_valid, ev);
    check("box_x0", box_x0, x0);
    check("box_x1", box_x1, x1);
    check("box_y0", box_y0, y0);
    check("box_y1", box_y1, y1);
    check("box_cx", box_cx, cx);
    check("box_cy", box_cy, cy);
    m_v = ev; m_x0 = x0; m_x1 = x1; m_y0 = y0; m_y1 = y1;
    for (int y = 0; y < rows; y++)
      for (int x = 0; x < 8; x++) begin
        drive(1'b0, 1'b1, map[y*8+x] ? 8'hFF : 8'h7F, 3'(x), 3'(y));
        if (x == 0 && y == 0) check("frame_done_pulse", frame_done, 1'b0);
      end
  endtask

  initial begin
    logic [63:0] face_a, face_b, face_c, face_d;
    face_a = pt(2,3) | pt(5,3) | pt(4,6) | pt(3,4);
    face_b = pt(1,2) | pt(6,2) | pt(1,5) | pt(6,5);
    face_c = pt(0,1) | pt(3,2) | pt(2,6);
    face_d = pt(1,1) | pt(2,2) | pt(3,3) | pt(4,4);
    #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_pack", o_pack, '0);
    check("rst_valid", box_valid, 1'b0);
    check("rst_x1", box_x1, 3'd0);
    check("rst_done", frame_done, 1'b0);
    @(negedge clk) rstn = 1'b1;
    frame(64'd0, 8, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    frame(64'd0, 8, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
    en = 1'b1;
    frame(face_a, 8, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
    frame(64'd0, 8, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 2, 5, 3, 6, 3, 4);
    en = 1'b0;
    frame(face_a, 8, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 2, 5, 3, 6, 3, 4);
    frame(face_b, 8, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 2, 5, 3, 6, 3, 4);
    en = 1'b1;
    frame(face_c, 8, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 1, 6, 2, 5, 3, 3);
    frame(face_c, 8, 1'b1, 3'd7, 3'd7, 1'b1, 1'b0, 1, 6, 2, 5, 3, 3);
    frame(face_a, 4, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 0, 7, 1, 7, 3, 4);
    rstn = 1'b0;
    #2;
    check("mid_rst_o_pack", o_pack, '0);
    check("mid_rst_valid", box_valid, 1'b0);
    check("mid_rst_x1", box_x1, 3'd0);
    check("mid_rst_y1", box_y1, 3'd0);
    check("mid_rst_cy", box_cy, 3'd0);
    m_v = 1'b0; m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0;
    @(negedge clk) rstn = 1'b1;
    frame(face_d, 8, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    frame(64'd0, 8, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 1, 4, 1, 4, 2, 2);
    frame(64'd0, 0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1, 4, 1, 4, 2, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
